// File: rtl/fft_seq_ctrl_pkg.sv
// Shared types and constants for the radix-2 FFT sequencing controller.
package fft_pkg;

  localparam int unsigned N_LOG2_DEF = 10;
  localparam int unsigned BF_LAT_DEF = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_COMP,
    S_DRAIN,
    S_OUT
  } fft_state_e;

  function automatic int unsigned half_n(input int unsigned n_log2);
    return 32'd1 << (n_log2 - 1);
  endfunction

  // Cycles from the sampled start edge to the first valid output pair.
  function automatic int unsigned start_to_ready(input int unsigned n_log2,
                                                 input int unsigned bf_lat);
    return 1 + half_n(n_log2) + n_log2 * (half_n(n_log2) + bf_lat) + 1;
  endfunction

  localparam int unsigned HALF_N_DEF  = half_n(N_LOG2_DEF);
  localparam int unsigned LATENCY_DEF = start_to_ready(N_LOG2_DEF, BF_LAT_DEF);

  // Reverses the low 'width' bits of v; bits at or above width must be zero.
  function automatic logic [31:0] bitrev(input logic [31:0] v,
                                         input int unsigned width);
    logic [31:0] r;
    r = {<<{v}};
    return r >> (32 - width);
  endfunction

endpackage

// File: rtl/fft_seq_ctrl_if.sv
// Control bus between the FFT sequencer (master) and the memory/butterfly datapath (slave).
interface fft_seq_ctrl_if
  import fft_pkg::*;
#(
  parameter int unsigned N_LOG2 = N_LOG2_DEF
);

  logic              start_i;
  logic              busy_o;
  logic              load_we_o;
  logic [N_LOG2-2:0] load_addr_o;
  logic              rd_en_o;
  logic [N_LOG2-1:0] rd_addr0_o;
  logic [N_LOG2-1:0] rd_addr1_o;
  logic              bf_valid_o;
  logic [N_LOG2-2:0] tw_addr_o;
  logic              wr_en_o;
  logic [N_LOG2-1:0] wr_addr0_o;
  logic [N_LOG2-1:0] wr_addr1_o;
  logic              bank_sel_o;
  logic [N_LOG2-1:0] stage_o;
  logic              fft_ready_o;
  logic              done_o;

  modport master (
    input  start_i,
    output busy_o, load_we_o, load_addr_o, rd_en_o, rd_addr0_o, rd_addr1_o,
           bf_valid_o, tw_addr_o, wr_en_o, wr_addr0_o, wr_addr1_o,
           bank_sel_o, stage_o, fft_ready_o, done_o
  );

  modport slave (
    output start_i,
    input  busy_o, load_we_o, load_addr_o, rd_en_o, rd_addr0_o, rd_addr1_o,
           bf_valid_o, tw_addr_o, wr_en_o, wr_addr0_o, wr_addr1_o,
           bank_sel_o, stage_o, fft_ready_o, done_o
  );

endinterface

// File: rtl/fft_seq_ctrl_addr_dly.sv
// Write-address delay line: carries {valid, addr0, addr1} from read issue to butterfly write-back.
module fft_addr_dly #(
  parameter int unsigned AW    = 10,
  parameter int unsigned DEPTH = 3
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          in_valid,
  input  logic [AW-1:0] in_addr0,
  input  logic [AW-1:0] in_addr1,
  output logic          out_valid,
  output logic [AW-1:0] out_addr0,
  output logic [AW-1:0] out_addr1
);

  localparam int unsigned W = 2 * AW + 1;

  logic [W-1:0] pipe_q [DEPTH];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= {in_valid, in_addr0, in_addr1};
      for (int unsigned i = 1; i < DEPTH; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign {out_valid, out_addr0, out_addr1} = pipe_q[DEPTH-1];

endmodule

// File: rtl/fft_seq_ctrl.sv
// Sequencer for a 2-sample-per-cycle radix-2 DIF FFT: load, log2(N) stages with drain,
// then bit-reversed readout from the ping-pong sample memory.
module fft_seq_ctrl
  import fft_pkg::*;
#(
  parameter int unsigned N_LOG2 = N_LOG2_DEF,
  parameter int unsigned BF_LAT = BF_LAT_DEF
) (
  input  logic           clk,
  input  logic           rstn,
  fft_seq_ctrl_if.master bus
);

  localparam int unsigned        KW     = N_LOG2 - 1;
  localparam int unsigned        DW     = (BF_LAT > 1) ? $clog2(BF_LAT) : 1;
  localparam logic [KW-1:0]      K_LAST = '1;
  localparam logic [DW-1:0]      D_LAST = DW'(BF_LAT - 1);
  localparam logic [N_LOG2-1:0]  S_LAST = N_LOG2'(N_LOG2 - 1);

  fft_state_e        state_q, state_d;
  logic              start_q;
  logic [KW-1:0]     k_q;
  logic [DW-1:0]     d_q;
  logic [N_LOG2-1:0] s_q;
  logic              bank_q;
  logic              bf_valid_q;
  logic              ready_q;
  logic              last_q;
  logic              done_q;

  logic              k_end, d_end, s_end, start_edge;
  logic              issue;
  logic              load_we;
  logic [KW-1:0]     load_addr;
  logic              rd_en;
  logic [N_LOG2-1:0] rd_addr0, rd_addr1;
  logic [KW-1:0]     tw_addr;
  logic [N_LOG2-1:0] wa0, wa1;
  logic              dly_valid;
  logic [N_LOG2-1:0] dly_a0, dly_a1;

  assign k_end = (k_q == K_LAST);
  assign d_end = (d_q == D_LAST);
  assign s_end = (s_q == S_LAST);
  // The done cycle is blocked so a start edge coinciding with it cannot launch a frame.
  assign start_edge = bus.start_i & ~start_q & ~done_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    issue     = 1'b0;
    load_we   = 1'b0;
    load_addr = '0;
    rd_en     = 1'b0;
    rd_addr0  = '0;
    rd_addr1  = '0;
    tw_addr   = '0;
    case (state_q)
      S_IDLE: begin
        if (start_edge) state_d = S_LOAD;
      end
      S_LOAD: begin
        load_we   = 1'b1;
        load_addr = k_q;
        if (k_end) state_d = S_COMP;
      end
      S_COMP: begin
        issue    = 1'b1;
        rd_en    = 1'b1;
        rd_addr0 = {1'b0, k_q};
        rd_addr1 = {1'b1, k_q};
        tw_addr  = (k_q >> s_q) << s_q;
        if (k_end) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (d_end) state_d = s_end ? S_OUT : S_COMP;
      end
      S_OUT: begin
        rd_en    = 1'b1;
        rd_addr0 = N_LOG2'(bitrev(32'({1'b0, k_q}), N_LOG2));
        rd_addr1 = N_LOG2'(bitrev(32'({1'b1, k_q}), N_LOG2));
        if (k_end) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // k wraps to zero on its own at the end of each N/2-cycle phase since K_LAST is all ones.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      start_q    <= 1'b0;
      k_q        <= '0;
      d_q        <= '0;
      s_q        <= '0;
      bank_q     <= 1'b0;
      bf_valid_q <= 1'b0;
      ready_q    <= 1'b0;
      last_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      start_q    <= bus.start_i;
      bf_valid_q <= (state_q == S_COMP);
      ready_q    <= (state_q == S_OUT);
      last_q     <= (state_q == S_OUT) && k_end;
      done_q     <= last_q;
      case (state_q)
        S_LOAD, S_COMP: begin
          k_q <= k_q + 1'b1;
        end
        S_DRAIN: begin
          k_q <= '0;
          if (d_end) begin
            d_q    <= '0;
            bank_q <= ~bank_q;
            if (!s_end) s_q <= s_q + 1'b1;
          end else begin
            d_q <= d_q + 1'b1;
          end
        end
        S_OUT: begin
          k_q <= k_q + 1'b1;
          if (k_end) begin
            s_q    <= '0;
            bank_q <= 1'b0;
          end
        end
        default: begin
          k_q <= '0;
          d_q <= '0;
        end
      endcase
    end
  end

  assign wa0 = issue ? {k_q, 1'b0} : '0;
  assign wa1 = issue ? {k_q, 1'b1} : '0;

  fft_addr_dly #(
    .AW    (N_LOG2),
    .DEPTH (BF_LAT)
  ) u_addr_dly (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (issue),
    .in_addr0  (wa0),
    .in_addr1  (wa1),
    .out_valid (dly_valid),
    .out_addr0 (dly_a0),
    .out_addr1 (dly_a1)
  );

  assign bus.busy_o      = (state_q != S_IDLE);
  assign bus.load_we_o   = load_we;
  assign bus.load_addr_o = load_addr;
  assign bus.rd_en_o     = rd_en;
  assign bus.rd_addr0_o  = rd_addr0;
  assign bus.rd_addr1_o  = rd_addr1;
  assign bus.bf_valid_o  = bf_valid_q;
  assign bus.tw_addr_o   = tw_addr;
  assign bus.wr_en_o     = dly_valid;
  assign bus.wr_addr0_o  = dly_a0;
  assign bus.wr_addr1_o  = dly_a1;
  assign bus.bank_sel_o  = bank_q;
  assign bus.stage_o     = s_q;
  assign bus.fft_ready_o = ready_q;
  assign bus.done_o      = done_q;

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// Self-checking bench for fft_seq_ctrl: three configurations compared cycle by cycle
// against a schedule model derived from the phase lengths.
module tb_fft_seq_ctrl;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fft_seq_ctrl_if #(.N_LOG2(2))  if_a ();
  fft_seq_ctrl_if #(.N_LOG2(10)) if_b ();
  fft_seq_ctrl_if #(.N_LOG2(3))  if_c ();

  fft_seq_ctrl #(.N_LOG2(2),  .BF_LAT(3)) dut_a (.clk(clk), .rstn(rstn), .bus(if_a));
  fft_seq_ctrl #(.N_LOG2(10), .BF_LAT(3)) dut_b (.clk(clk), .rstn(rstn), .bus(if_b));
  fft_seq_ctrl #(.N_LOG2(3),  .BF_LAT(1)) dut_c (.clk(clk), .rstn(rstn), .bus(if_c));

  typedef struct packed {
    logic        busy, load_we, rd_en, bf_valid, wr_en, ready, done, bank;
    logic [31:0] stage, load_addr, rd0, rd1, tw, wa0, wa1;
    logic        comp;
  } obs_t;

  function automatic int nl_of(int w);
    return (w == 0) ? 2 : (w == 1) ? 10 : 3;
  endfunction

  function automatic int lat_of(int w);
    return (w == 2) ? 1 : 3;
  endfunction

  function automatic obs_t get_obs(int w);
    obs_t o = '0;
    if (w == 0) begin
      o.busy = if_a.busy_o; o.load_we = if_a.load_we_o; o.rd_en = if_a.rd_en_o;
      o.bf_valid = if_a.bf_valid_o; o.wr_en = if_a.wr_en_o; o.ready = if_a.fft_ready_o;
      o.done = if_a.done_o; o.bank = if_a.bank_sel_o; o.stage = 32'(if_a.stage_o);
      o.load_addr = 32'(if_a.load_addr_o); o.rd0 = 32'(if_a.rd_addr0_o);
      o.rd1 = 32'(if_a.rd_addr1_o); o.tw = 32'(if_a.tw_addr_o);
      o.wa0 = 32'(if_a.wr_addr0_o); o.wa1 = 32'(if_a.wr_addr1_o);
    end else if (w == 1) begin
      o.busy = if_b.busy_o; o.load_we = if_b.load_we_o; o.rd_en = if_b.rd_en_o;
      o.bf_valid = if_b.bf_valid_o; o.wr_en = if_b.wr_en_o; o.ready = if_b.fft_ready_o;
      o.done = if_b.done_o; o.bank = if_b.bank_sel_o; o.stage = 32'(if_b.stage_o);
      o.load_addr = 32'(if_b.load_addr_o); o.rd0 = 32'(if_b.rd_addr0_o);
      o.rd1 = 32'(if_b.rd_addr1_o); o.tw = 32'(if_b.tw_addr_o);
      o.wa0 = 32'(if_b.wr_addr0_o); o.wa1 = 32'(if_b.wr_addr1_o);
    end else begin
      o.busy = if_c.busy_o; o.load_we = if_c.load_we_o; o.rd_en = if_c.rd_en_o;
      o.bf_valid = if_c.bf_valid_o; o.wr_en = if_c.wr_en_o; o.ready = if_c.fft_ready_o;
      o.done = if_c.done_o; o.bank = if_c.bank_sel_o; o.stage = 32'(if_c.stage_o);
      o.load_addr = 32'(if_c.load_addr_o); o.rd0 = 32'(if_c.rd_addr0_o);
      o.rd1 = 32'(if_c.rd_addr1_o); o.tw = 32'(if_c.tw_addr_o);
      o.wa0 = 32'(if_c.wr_addr0_o); o.wa1 = 32'(if_c.wr_addr1_o);
    end
    return o;
  endfunction

  task automatic set_start(input int w, input logic v);
    if (w == 0) if_a.start_i = v;
    else if (w == 1) if_b.start_i = v;
    else if_c.start_i = v;
  endtask

  function automatic int rev(int v, int n);
    int r = 0;
    for (int i = 0; i < n; i++) if (((v >> i) & 1) != 0) r |= 1 << (n - 1 - i);
    return r;
  endfunction

  // Is cycle v (counted from the start sample cycle) a butterfly issue cycle? k = pair index.
  function automatic bit issue_k(int w, int v, output int k);
    int nl = nl_of(w);
    int h  = 1 << (nl - 1);
    int p  = h + lat_of(w);
    int c0 = h + 1;
    k = 0;
    if (v < c0 || v >= c0 + nl * p) return 0;
    k = (v - c0) % p;
    return k < h;
  endfunction

  // Expected outputs u cycles after the cycle in which the start edge is sampled.
  function automatic obs_t model(int w, int u);
    int   nl = nl_of(w);
    int   l  = lat_of(w);
    int   h  = 1 << (nl - 1);
    int   p  = h + l;
    int   c0 = h + 1;
    int   o0 = c0 + nl * p;
    int   s, q, k;
    obs_t e = '0;
    if (u >= 1 && u <= h) begin
      e.busy = 1; e.load_we = 1; e.load_addr = u - 1;
    end else if (u >= c0 && u < o0) begin
      s = (u - c0) / p; q = (u - c0) % p;
      e.busy = 1; e.stage = s; e.bank = (s % 2) != 0;
      if (q < h) begin
        e.rd_en = 1; e.comp = 1; e.rd0 = q; e.rd1 = q + h; e.tw = (q >> s) << s;
      end
    end else if (u >= o0 && u < o0 + h) begin
      k = u - o0;
      e.busy = 1; e.stage = nl - 1; e.bank = (nl % 2) != 0;
      e.rd_en = 1; e.rd0 = rev(k, nl); e.rd1 = rev(k + h, nl);
    end
    if (issue_k(w, u - 1, k)) e.bf_valid = 1;
    if (issue_k(w, u - l, k)) begin
      e.wr_en = 1; e.wa0 = 2 * k; e.wa1 = 2 * k + 1;
    end
    e.ready = (u - 1 >= o0) && (u - 1 < o0 + h);
    e.done  = (u == o0 + h + 1);
    return e;
  endfunction

  // mode 0: short start pulse; 1: start toggled during COMP then held high;
  // 2: start rises in the done cycle and stays high.
  task automatic run_frame(input int w, input int mode,
                           output int first_ready, output int n_ready, output int n_done);
    int nl = nl_of(w);
    int h  = 1 << (nl - 1);
    int p  = h + lat_of(w);
    int c0 = h + 1;
    int o0 = c0 + nl * p;
    int pulse = $urandom_range(1, 3);
    logic [7:0] av, ev;
    obs_t a, e;
    first_ready = -1; n_ready = 0; n_done = 0;
    set_start(w, 1'b0);
    repeat ($urandom_range(1, 4)) @(posedge clk);
    #1 set_start(w, 1'b1);
    for (int u = 1; u <= o0 + h + 4; u++) begin
      @(posedge clk);
      #1;
      a = get_obs(w);
      e = model(w, u);
      av = {a.busy, a.load_we, a.rd_en, a.bf_valid, a.wr_en, a.ready, a.done, a.bank};
      ev = {e.busy, e.load_we, e.rd_en, e.bf_valid, e.wr_en, e.ready, e.done, e.bank};
      checks++;
      if (av !== ev) begin
        errors++;
        $display("FAIL inst%0d u=%0d strobes{busy,ld,rd,bfv,wr,rdy,done,bank} got %b want %b", w, u, av, ev);
      end
      checks++;
      if (a.stage !== e.stage) begin
        errors++;
        $display("FAIL inst%0d u=%0d stage got %0d want %0d", w, u, a.stage, e.stage);
      end
      if (e.load_we) begin
        checks++;
        if (a.load_addr !== e.load_addr) begin
          errors++;
          $display("FAIL inst%0d u=%0d load_addr got %0d want %0d", w, u, a.load_addr, e.load_addr);
        end
      end
      if (e.rd_en) begin
        checks++;
        if (a.rd0 !== e.rd0 || a.rd1 !== e.rd1) begin
          errors++;
          $display("FAIL inst%0d u=%0d rd_addr got %0d,%0d want %0d,%0d", w, u, a.rd0, a.rd1, e.rd0, e.rd1);
        end
      end
      if (e.comp) begin
        checks++;
        if (a.tw !== e.tw) begin
          errors++;
          $display("FAIL inst%0d u=%0d tw_addr got %0d want %0d", w, u, a.tw, e.tw);
        end
      end
      if (e.wr_en) begin
        checks++;
        if (a.wa0 !== e.wa0 || a.wa1 !== e.wa1) begin
          errors++;
          $display("FAIL inst%0d u=%0d wr_addr got %0d,%0d want %0d,%0d", w, u, a.wa0, a.wa1, e.wa0, e.wa1);
        end
      end
      if (a.ready === 1'b1) begin
        n_ready++;
        if (first_ready < 0) first_ready = u;
      end
      if (a.done === 1'b1) n_done++;
      case (mode)
        1:       set_start(w, (u < c0 + p + h) ? logic'($urandom_range(0, 1)) : 1'b1);
        2:       set_start(w, (u < pulse) || (u >= o0 + h + 1));
        default: set_start(w, u < pulse);
      endcase
    end
    set_start(w, 1'b0);
  endtask

  task automatic check_stats(input int w, input string tag,
                             input int first_ready, input int n_ready, input int n_done);
    int nl = nl_of(w);
    int h  = 1 << (nl - 1);
    int lat = 1 + h + nl * (h + lat_of(w)) + 1;
    checks++;
    if (first_ready != lat) begin
      errors++;
      $display("FAIL %s first_ready_latency got %0d want %0d", tag, first_ready, lat);
    end
    checks++;
    if (n_ready != h) begin
      errors++;
      $display("FAIL %s ready_cycles got %0d want %0d", tag, n_ready, h);
    end
    checks++;
    if (n_done != 1) begin
      errors++;
      $display("FAIL %s done_pulses got %0d want 1", tag, n_done);
    end
  endtask

  task automatic test_reset();
    obs_t a;
    set_start(0, 1'b0); set_start(1, 1'b0); set_start(2, 1'b0);
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int w = 0; w < 3; w++) begin
      a = get_obs(w);
      checks++;
      if (a !== '0) begin
        errors++;
        $display("FAIL reset_in inst%0d outputs got %h want 0", w, a);
      end
    end
    rstn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int w = 0; w < 3; w++) begin
      a = get_obs(w);
      checks++;
      if (a !== '0) begin
        errors++;
        $display("FAIL reset_idle inst%0d outputs got %h want 0", w, a);
      end
    end
  endtask

  task automatic test_frame_small();
    int fr, nr, nd;
    run_frame(0, 0, fr, nr, nd);
    check_stats(0, "small", fr, nr, nd);
  endtask

  task automatic test_start_ignore();
    int fr, nr, nd;
    run_frame(0, 1, fr, nr, nd);
    check_stats(0, "start_noise", fr, nr, nd);
    run_frame(0, 2, fr, nr, nd);
    check_stats(0, "start_at_done", fr, nr, nd);
  endtask

  task automatic test_back_to_back();
    int fr, nr, nd;
    for (int i = 0; i < 3; i++) begin
      run_frame(0, 0, fr, nr, nd);
      check_stats(0, "back_to_back", fr, nr, nd);
    end
  endtask

  task automatic test_bf_lat1();
    int fr, nr, nd;
    run_frame(2, 0, fr, nr, nd);
    check_stats(2, "bf_lat1", fr, nr, nd);
    run_frame(2, 1, fr, nr, nd);
    check_stats(2, "bf_lat1_noise", fr, nr, nd);
  endtask

  task automatic test_large();
    int fr, nr, nd;
    run_frame(1, 0, fr, nr, nd);
    check_stats(1, "large", fr, nr, nd);
  endtask

  task automatic test_reset_abort();
    int   h = 512;
    int   target = (h + 1) + 4 * (h + 3) + $urandom_range(0, h - 1);
    int   fr, nr, nd;
    obs_t a;
    set_start(1, 1'b0);
    @(posedge clk);
    #1 set_start(1, 1'b1);
    for (int u = 1; u <= target; u++) begin
      @(posedge clk);
      #1;
      if (u == 1) set_start(1, 1'b0);
    end
    a = get_obs(1);
    checks++;
    if (a.stage !== 32'd4 || a.busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_pre stage/busy got %0d/%b want 4/1", a.stage, a.busy);
    end
    rstn = 1'b0;
    #2;
    a = get_obs(1);
    checks++;
    if (a !== '0) begin
      errors++;
      $display("FAIL abort_same_cycle outputs got %h want 0", a);
    end
    @(posedge clk);
    #1 rstn = 1'b1;
    run_frame(1, 0, fr, nr, nd);
    check_stats(1, "after_abort", fr, nr, nd);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_frame_small();
    test_start_ignore();
    test_back_to_back();
    test_bf_lat1();
    test_large();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
